// File: rtl/dmem_pkg.sv
// Shared types and defaults for the M-stage data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } dmem_state_e;

    localparam int unsigned DefAddrW = 8;
    localparam int unsigned DefLat   = 2;
    localparam int unsigned DefCntW  = 4;

    localparam logic [1:0] MisalignMask = 2'b11;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] & MisalignMask) != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide storage: asynchronous read port, one synchronous write port, no reset.
module dmem_array #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wd,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rd
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [31:0] r_mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wd;
        end
    end

    assign rd = r_mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with LAT wait states, stall request and misalignment pulse.
// Optional access/stall counters are built when DMEM_STATS_EN is defined.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned LAT    = DefLat,
    parameter int unsigned CNT_W  = DefCntW
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memreadM,
    input  logic        memwriteM,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall_mem,
    output logic        err_misalign
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] stat_rd,
    output logic [31:0] stat_wr,
    output logic [31:0] stat_stall
`endif
);

    localparam bit               LatZero = (LAT == 0);
    localparam logic [CNT_W-1:0] CntLoad = CNT_W'((LAT == 0) ? 0 : LAT - 1);

    dmem_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;

    logic              w_req;
    logic              w_misalign;
    logic              w_access;
    logic              w_we;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       w_rd;
    logic              w_unused_addr;

    assign w_req         = memreadM | memwriteM;
    assign w_misalign    = is_misaligned(addr);
    assign w_idx         = addr[ADDR_W+1:2];
    assign w_unused_addr = ^addr[31:ADDR_W+2];

    // Counter holds the remaining WAIT cycles; reaching zero hands over to DONE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (!LatZero && w_req && !w_misalign) begin
                        r_cnt   <= CntLoad;
                        r_state <= (CntLoad == '0) ? StDone : StWait;
                    end
                end
                StWait: begin
                    if (!w_req) begin
                        r_cnt   <= '0;
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= StDone;
                        end
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // The array is touched only in the completing cycle of an aligned access.
    always_comb begin
        w_access = 1'b0;
        if (LatZero) begin
            w_access = (r_state == StIdle) && w_req && !w_misalign;
        end else begin
            w_access = (r_state == StDone) && w_req;
        end
        w_access = w_access && rst;
    end

    assign w_we = w_access && memwriteM;

    always_comb begin
        stall_mem = 1'b0;
        if (!LatZero && rst) begin
            stall_mem = ((r_state == StIdle) && w_req && !w_misalign) ||
                        ((r_state == StWait) && w_req);
        end
    end

    assign err_misalign = rst && (r_state == StIdle) && w_req && w_misalign;
    assign rdata        = w_access ? w_rd : 32'h0;

    dmem_array #(
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk  (clk),
        .we   (w_we),
        .waddr(w_idx),
        .wd   (wdata),
        .raddr(w_idx),
        .rd   (w_rd)
    );

`ifdef DMEM_STATS_EN
    logic [31:0] r_stat_rd;
    logic [31:0] r_stat_wr;
    logic [31:0] r_stat_stall;

    // A simultaneous read+write request counts as a store only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stat_rd    <= '0;
            r_stat_wr    <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_access && memreadM && !memwriteM && (r_stat_rd != '1)) begin
                r_stat_rd <= r_stat_rd + 32'd1;
            end
            if (w_we && (r_stat_wr != '1)) begin
                r_stat_wr <= r_stat_wr + 32'd1;
            end
            if (stall_mem && (r_stat_stall != '1)) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_rd    = r_stat_rd;
    assign stat_wr    = r_stat_wr;
    assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Table-driven bench for dmem_responder with LAT=0, 2 and 3 instances.
// Counter checks are included when DMEM_STATS_EN is defined.
module tb_dmem_responder;

    typedef struct {
        int unsigned lat;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        stall;
        logic        chk_rdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rd0, wr0, rd2, wr2, rd3, wr3;
    logic [31:0] a0, a2, a3, wd0, wd2, wd3;
    logic [31:0] rdata0, rdata2, rdata3;
    logic stall0, stall2, stall3, err0, err2, err3;
`ifdef DMEM_STATS_EN
    logic [31:0] srd0, swr0, sst0, srd2, swr2, sst2, srd3, swr3, sst3;
`endif

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    dmem_responder #(.ADDR_W(8), .LAT(0), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .memreadM(rd0), .memwriteM(wr0), .addr(a0), .wdata(wd0),
        .rdata(rdata0), .stall_mem(stall0), .err_misalign(err0)
`ifdef DMEM_STATS_EN
        , .stat_rd(srd0), .stat_wr(swr0), .stat_stall(sst0)
`endif
    );

    dmem_responder #(.ADDR_W(8), .LAT(2), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .memreadM(rd2), .memwriteM(wr2), .addr(a2), .wdata(wd2),
        .rdata(rdata2), .stall_mem(stall2), .err_misalign(err2)
`ifdef DMEM_STATS_EN
        , .stat_rd(srd2), .stat_wr(swr2), .stat_stall(sst2)
`endif
    );

    dmem_responder #(.ADDR_W(8), .LAT(3), .CNT_W(4)) u_dut3 (
        .clk(clk), .rst(rst), .memreadM(rd3), .memwriteM(wr3), .addr(a3), .wdata(wd3),
        .rdata(rdata3), .stall_mem(stall3), .err_misalign(err3)
`ifdef DMEM_STATS_EN
        , .stat_rd(srd3), .stat_wr(swr3), .stat_stall(sst3)
`endif
    );

    function automatic vec_t mk(input int unsigned lat, input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic stall, input logic chk,
                                input logic [31:0] rdata, input logic err);
        vec_t v;
        v.lat = lat;   v.rd = rd;   v.wr = wr;   v.addr = addr;  v.wdata = wdata;
        v.stall = stall; v.chk_rdata = chk; v.rdata = rdata; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rd0 = 1'b0; wr0 = 1'b0; a0 = '0; wd0 = '0;
        rd2 = 1'b0; wr2 = 1'b0; a2 = '0; wd2 = '0;
        rd3 = 1'b0; wr3 = 1'b0; a3 = '0; wd3 = '0;
        case (v.lat)
            0: begin rd0 = v.rd; wr0 = v.wr; a0 = v.addr; wd0 = v.wdata; end
            2: begin rd2 = v.rd; wr2 = v.wr; a2 = v.addr; wd2 = v.wdata; end
            3: begin rd3 = v.rd; wr3 = v.wr; a3 = v.addr; wd3 = v.wdata; end
            default: ;
        endcase
    endtask

    // One vector = one clock cycle: drive after the falling edge, sample 1 ns later.
    task automatic run(input vec_t v, input string tag);
        logic        st;
        logic        er;
        logic [31:0] rdv;
        @(negedge clk);
        drive(v);
        #1;
        case (v.lat)
            0:       begin st = stall0; er = err0; rdv = rdata0; end
            2:       begin st = stall2; er = err2; rdv = rdata2; end
            default: begin st = stall3; er = err3; rdv = rdata3; end
        endcase
        check($sformatf("%s stall", tag), 32'(st), 32'(v.stall));
        check($sformatf("%s err", tag), 32'(er), 32'(v.err));
        if (v.chk_rdata) begin
            check($sformatf("%s rdata", tag), rdv, v.rdata);
        end
    endtask

    initial begin
        // LAT=2: store, load, back-to-back load, misalignment, aliasing, read+write
        vecs.push_back(mk(2, 0, 1, 32'h10, 32'hDEADBEEF, 1, 1, 32'h0, 0));
        vecs.push_back(mk(2, 0, 1, 32'h10, 32'hDEADBEEF, 1, 1, 32'h0, 0));
        vecs.push_back(mk(2, 0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 0));
        vecs.push_back(mk(2, 0, 0, 32'h0, 32'h0, 0, 1, 32'h0, 0));
        for (int k = 0; k < 2; k++) begin
            vecs.push_back(mk(2, 1, 0, 32'h10, 32'h0, 1, 1, 32'h0, 0));
            vecs.push_back(mk(2, 1, 0, 32'h10, 32'h0, 1, 1, 32'h0, 0));
            vecs.push_back(mk(2, 1, 0, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF, 0));
        end
        vecs.push_back(mk(2, 1, 0, 32'h13, 32'h0, 0, 1, 32'h0, 1));
        vecs.push_back(mk(2, 0, 1, 32'h11, 32'hBAD, 0, 1, 32'h0, 1));
        vecs.push_back(mk(2, 0, 0, 32'h0, 32'h0, 0, 1, 32'h0, 0));
        vecs.push_back(mk(2, 1, 0, 32'h10, 32'h0, 1, 1, 32'h0, 0));
        vecs.push_back(mk(2, 1, 0, 32'h10, 32'h0, 1, 1, 32'h0, 0));
        vecs.push_back(mk(2, 1, 0, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF, 0));
        vecs.push_back(mk(2, 0, 1, 32'h400, 32'h11112222, 1, 1, 32'h0, 0));
        vecs.push_back(mk(2, 0, 1, 32'h400, 32'h11112222, 1, 1, 32'h0, 0));
        vecs.push_back(mk(2, 0, 1, 32'h400, 32'h11112222, 0, 0, 32'h0, 0));
        vecs.push_back(mk(2, 1, 0, 32'h0, 32'h0, 1, 1, 32'h0, 0));
        vecs.push_back(mk(2, 1, 0, 32'h0, 32'h0, 1, 1, 32'h0, 0));
        vecs.push_back(mk(2, 1, 0, 32'h0, 32'h0, 0, 1, 32'h11112222, 0));
        vecs.push_back(mk(2, 1, 1, 32'h10, 32'hCAFEF00D, 1, 1, 32'h0, 0));
        vecs.push_back(mk(2, 1, 1, 32'h10, 32'hCAFEF00D, 1, 1, 32'h0, 0));
        vecs.push_back(mk(2, 1, 1, 32'h10, 32'hCAFEF00D, 0, 1, 32'hDEADBEEF, 0));
        vecs.push_back(mk(2, 1, 0, 32'h10, 32'h0, 1, 1, 32'h0, 0));
        vecs.push_back(mk(2, 1, 0, 32'h10, 32'h0, 1, 1, 32'h0, 0));
        vecs.push_back(mk(2, 1, 0, 32'h10, 32'h0, 0, 1, 32'hCAFEF00D, 0));
        // LAT=0: single-cycle access, never stalls
        vecs.push_back(mk(0, 0, 1, 32'h4, 32'h7, 0, 0, 32'h0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h4, 32'h0, 0, 1, 32'h7, 0));
        vecs.push_back(mk(0, 1, 0, 32'h13, 32'h0, 0, 1, 32'h0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0, 32'h0, 0, 1, 32'h0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h404, 32'h0, 0, 1, 32'h7, 0));
        // LAT=3: establish old value, then abort a store in its second WAIT cycle
        for (int k = 0; k < 3; k++) begin
            vecs.push_back(mk(3, 0, 1, 32'h20, 32'hAAAA, 1, 1, 32'h0, 0));
        end
        vecs.push_back(mk(3, 0, 1, 32'h20, 32'hAAAA, 0, 0, 32'h0, 0));
        vecs.push_back(mk(3, 0, 1, 32'h20, 32'h55, 1, 1, 32'h0, 0));
        vecs.push_back(mk(3, 0, 1, 32'h20, 32'h55, 1, 1, 32'h0, 0));
        vecs.push_back(mk(3, 0, 0, 32'h20, 32'h55, 0, 1, 32'h0, 0));
        vecs.push_back(mk(3, 0, 0, 32'h0, 32'h0, 0, 1, 32'h0, 0));
        for (int k = 0; k < 3; k++) begin
            vecs.push_back(mk(3, 1, 0, 32'h20, 32'h0, 1, 1, 32'h0, 0));
        end
        vecs.push_back(mk(3, 1, 0, 32'h20, 32'h0, 0, 1, 32'hAAAA, 0));

        // Reset with a request pending on every instance: outputs must stay quiet
        rst = 1'b0;
        drive(mk(0, 1, 0, 32'h4, 32'h0, 0, 0, 32'h0, 0));
        rd2 = 1'b1; a2 = 32'h10; rd3 = 1'b1; a3 = 32'h20;
        repeat (2) @(negedge clk);
        #1;
        check("reset stall0", 32'(stall0), 32'h0);
        check("reset stall2", 32'(stall2), 32'h0);
        check("reset stall3", 32'(stall3), 32'h0);
        check("reset err0", 32'(err0), 32'h0);
        check("reset rdata0", rdata0, 32'h0);
        check("reset rdata2", rdata2, 32'h0);
        drive(mk(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0));
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run(vecs[i], $sformatf("v%0d", i));
        end

        // Reset during WAIT discards the pending store to 0x10
        run(mk(2, 0, 1, 32'h10, 32'h12345678, 1, 1, 32'h0, 0), "rstwait req");
        run(mk(2, 0, 1, 32'h10, 32'h12345678, 1, 1, 32'h0, 0), "rstwait wait");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstwait in-reset stall", 32'(stall2), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(mk(2, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0));
        #1;
        check("rstwait after stall", 32'(stall2), 32'h0);
        run(mk(2, 1, 0, 32'h10, 32'h0, 1, 1, 32'h0, 0), "rstwait ld1");
        run(mk(2, 1, 0, 32'h10, 32'h0, 1, 1, 32'h0, 0), "rstwait ld2");
        run(mk(2, 1, 0, 32'h10, 32'h0, 0, 1, 32'hCAFEF00D, 0), "rstwait ld3");

`ifdef DMEM_STATS_EN
        @(negedge clk);
        rst = 1'b0;
        drive(mk(2, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("stat_rd reset", srd2, 32'h0);
        check("stat_stall reset", sst2, 32'h0);
        for (int k = 0; k < 3; k++) begin
            run(mk(2, 1, 0, 32'h10, 32'h0, 1, 1, 32'h0, 0), "st ld");
            run(mk(2, 1, 0, 32'h10, 32'h0, 1, 1, 32'h0, 0), "st ld");
            run(mk(2, 1, 0, 32'h10, 32'h0, 0, 1, 32'hCAFEF00D, 0), "st ld");
        end
        for (int k = 0; k < 2; k++) begin
            run(mk(2, 0, 1, 32'h0, 32'h11112222, 1, 1, 32'h0, 0), "st sw");
            run(mk(2, 0, 1, 32'h0, 32'h11112222, 1, 1, 32'h0, 0), "st sw");
            run(mk(2, 0, 1, 32'h0, 32'h11112222, 0, 0, 32'h0, 0), "st sw");
        end
        @(negedge clk);
        drive(mk(2, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0));
        #1;
        check("stat_rd", srd2, 32'd3);
        check("stat_wr", swr2, 32'd2);
        check("stat_stall", sst2, 32'd10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
